writeback_regfile: RTL

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/writeback_regfile.sv
// Y86 writeback stage and 15 x 64-bit register file with RUN/HALT/ERR status FSM.
// Optional macro WB_FORWARD_EN: decode reads see the value committed this cycle.
module writeback_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [1:0]  stat,
    output logic [31:0] retired,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;

    typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, ERR = 2'd2} state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] regs [0:14];
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [1:0]  commit_stat;
    logic [1:0]  err_code;
    logic        commit;
    logic        write_en;

    // Handshake: an instruction is consumed on any rising edge where wb_valid && wb_ready;
    // wb_ready depends only on FSM state, never on wb_valid.
    assign commit    = wb_valid && wb_ready;
    assign write_en  = commit && (commit_stat == STAT_AOK);
    assign dbg_state = state;

    always_comb begin
        dst_e = REG_NONE;
        case (icode)
            4'h2:                   dst_e = cnd ? rB : REG_NONE;
            4'h3, 4'h6:             dst_e = rB;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = REG_RSP;
            default:                dst_e = REG_NONE;
        endcase
    end

    always_comb begin
        dst_m = REG_NONE;
        if (icode == 4'h5 || icode == 4'hB)
            dst_m = rA;
    end

    always_comb begin
        commit_stat = STAT_AOK;
        if (imem_error || dmem_error)
            commit_stat = STAT_ADR;
        else if (!instr_valid)
            commit_stat = 2'b11;
        else if (icode == 4'h0)
            commit_stat = STAT_HLT;
    end

    always_comb begin
        next_state = state;
        wb_ready   = 1'b0;
        stat       = STAT_AOK;
        case (state)
            RUN: begin
                wb_ready = 1'b1;
                if (commit && commit_stat == STAT_HLT)
                    next_state = HALT;
                else if (commit && commit_stat[1])
                    next_state = ERR;
            end
            HALT:    stat = STAT_HLT;
            ERR:     stat = err_code;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            err_code <= STAT_AOK;
            retired  <= '0;
        end else begin
            state <= next_state;
            if (commit && commit_stat[1])
                err_code <= commit_stat;
            if (commit && !commit_stat[1])
                retired <= retired + 32'd1;
        end
    end

    // When both destinations coincide (popq %rsp) the memory value wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= '0;
        end else if (write_en) begin
            if (dst_e != REG_NONE && dst_e != dst_m)
                regs[dst_e] <= valE;
            if (dst_m != REG_NONE)
                regs[dst_m] <= valM;
        end
    end

    always_comb begin
        valA = '0;
        valB = '0;
        if (srcA != REG_NONE)
            valA = regs[srcA];
        if (srcB != REG_NONE)
            valB = regs[srcB];
`ifdef WB_FORWARD_EN
        if (write_en && srcA != REG_NONE) begin
            if (srcA == dst_m)
                valA = valM;
            else if (srcA == dst_e)
                valA = valE;
        end
        if (write_en && srcB != REG_NONE) begin
            if (srcB == dst_m)
                valB = valM;
            else if (srcB == dst_e)
                valB = valE;
        end
`endif
    end

endmodule
